// File: rtl/msx2p_debug_rx.sv
// msx2p_debug_rx: 8N1 UART receiver and single-character debug command parser, all in the 27 MHz domain.
// Define MSX2P_DEBUG_RX_BREAKPOINT_EN to build the 'b'/'c' breakpoint commands and the bp_addr/bp_valid logic.
module msx2p_debug_rx #(
    parameter int CLK_FREQ  = 27000000,
    parameter int UART_FREQ = 115200
) (
    input  logic        clk_27m,
    input  logic        reset,
    input  logic        uart_rx,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    output logic        framing_err,
    output logic        send,
    output logic        debug_clear,
    output logic [15:0] bp_addr,
    output logic        bp_valid,
    output logic        cmd_error
);

    localparam int CLKS_PER_BIT = CLK_FREQ / UART_FREQ;
    localparam int CW           = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    function automatic logic [7:0] to_lower(input logic [7:0] c);
        if (c >= 8'h41 && c <= 8'h5A) begin
            return c | 8'h20;
        end
        return c;
    endfunction

    logic            sync1_q;
    logic            rx_s_q;
    rx_state_t       rx_state_q, rx_state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic [7:0]      shift_q, shift_d;
    logic [7:0]      rx_data_q, rx_data_d;
    logic            rx_valid_q, rx_valid_d;
    logic            framing_err_q, framing_err_d;
    logic            send_q, send_d;
    logic            debug_clear_q, debug_clear_d;
    logic            cmd_error_q, cmd_error_d;
    logic [7:0]      cmd_char;

`ifdef MSX2P_DEBUG_RX_BREAKPOINT_EN
    typedef enum logic {
        CMD_IDLE,
        CMD_HEX
    } cmd_state_t;

    function automatic logic is_hex(input logic [7:0] c);
        return (c >= 8'h30 && c <= 8'h39) || (c >= 8'h61 && c <= 8'h66);
    endfunction

    // Caller has already folded A-F to a-f.
    function automatic logic [3:0] hex_nib(input logic [7:0] c);
        logic [7:0] v;
        v = (c <= 8'h39) ? (c - 8'h30) : (c - 8'h57);
        return v[3:0];
    endfunction

    cmd_state_t      cmd_state_q, cmd_state_d;
    logic [15:0]     hex_q, hex_d;
    logic [1:0]      digits_q, digits_d;
    logic [15:0]     bp_addr_q, bp_addr_d;
    logic            bp_valid_q, bp_valid_d;
    logic [3:0]      nib;
`endif

    // Receiver: counts from the start edge to mid-bit, then samples once per bit period.
    always_comb begin
        rx_state_d    = rx_state_q;
        cnt_d         = cnt_q;
        bit_idx_d     = bit_idx_q;
        shift_d       = shift_q;
        rx_data_d     = rx_data_q;
        rx_valid_d    = 1'b0;
        framing_err_d = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                if (!rx_s_q) begin
                    rx_state_d = RX_START;
                    cnt_d      = '0;
                end
            end
            RX_START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d      = '0;
                    bit_idx_d  = '0;
                    rx_state_d = rx_s_q ? RX_IDLE : RX_DATA;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RX_DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d     = '0;
                    shift_d   = {rx_s_q, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        rx_state_d = RX_STOP;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RX_STOP: begin
                // Leaving mid-stop-bit lets the next start edge be seen without a gap.
                if (cnt_q == BIT_LAST) begin
                    cnt_d      = '0;
                    rx_state_d = RX_IDLE;
                    if (rx_s_q) begin
                        rx_data_d  = shift_q;
                        rx_valid_d = 1'b1;
                    end else begin
                        framing_err_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    assign cmd_char = to_lower(rx_data_q);
`ifdef MSX2P_DEBUG_RX_BREAKPOINT_EN
    assign nib = hex_nib(cmd_char);
`endif

    // Command parser reacts to the registered rx strobes, so its strobes trail rx_valid by one cycle.
    always_comb begin
        send_d        = 1'b0;
        debug_clear_d = 1'b0;
        cmd_error_d   = 1'b0;
`ifdef MSX2P_DEBUG_RX_BREAKPOINT_EN
        cmd_state_d   = cmd_state_q;
        hex_d         = hex_q;
        digits_d      = digits_q;
        bp_addr_d     = bp_addr_q;
        bp_valid_d    = bp_valid_q;
        if (cmd_state_q == CMD_HEX) begin
            if (framing_err_q) begin
                cmd_error_d = 1'b1;
                cmd_state_d = CMD_IDLE;
            end else if (rx_valid_q) begin
                if (is_hex(cmd_char)) begin
                    hex_d    = {hex_q[11:0], nib};
                    digits_d = digits_q + 2'd1;
                    if (digits_q == 2'd3) begin
                        bp_addr_d   = {hex_q[11:0], nib};
                        bp_valid_d  = 1'b1;
                        cmd_state_d = CMD_IDLE;
                    end
                end else begin
                    cmd_error_d = 1'b1;
                    cmd_state_d = CMD_IDLE;
                end
            end
        end else
`endif
        if (rx_valid_q) begin
            case (cmd_char)
                8'h73: send_d        = 1'b1;
                8'h72: debug_clear_d = 1'b1;
`ifdef MSX2P_DEBUG_RX_BREAKPOINT_EN
                8'h63: bp_valid_d    = 1'b0;
                8'h62: begin
                    cmd_state_d = CMD_HEX;
                    hex_d       = '0;
                    digits_d    = '0;
                end
`endif
                8'h0d, 8'h0a, 8'h20: begin
                end
                default: cmd_error_d = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk_27m) begin
        if (reset) begin
            sync1_q       <= 1'b1;
            rx_s_q        <= 1'b1;
            rx_state_q    <= RX_IDLE;
            cnt_q         <= '0;
            bit_idx_q     <= '0;
            shift_q       <= '0;
            rx_data_q     <= '0;
            rx_valid_q    <= 1'b0;
            framing_err_q <= 1'b0;
            send_q        <= 1'b0;
            debug_clear_q <= 1'b0;
            cmd_error_q   <= 1'b0;
`ifdef MSX2P_DEBUG_RX_BREAKPOINT_EN
            cmd_state_q   <= CMD_IDLE;
            hex_q         <= '0;
            digits_q      <= '0;
            bp_addr_q     <= '0;
            bp_valid_q    <= 1'b0;
`endif
        end else begin
            sync1_q       <= uart_rx;
            rx_s_q        <= sync1_q;
            rx_state_q    <= rx_state_d;
            cnt_q         <= cnt_d;
            bit_idx_q     <= bit_idx_d;
            shift_q       <= shift_d;
            rx_data_q     <= rx_data_d;
            rx_valid_q    <= rx_valid_d;
            framing_err_q <= framing_err_d;
            send_q        <= send_d;
            debug_clear_q <= debug_clear_d;
            cmd_error_q   <= cmd_error_d;
`ifdef MSX2P_DEBUG_RX_BREAKPOINT_EN
            cmd_state_q   <= cmd_state_d;
            hex_q         <= hex_d;
            digits_q      <= digits_d;
            bp_addr_q     <= bp_addr_d;
            bp_valid_q    <= bp_valid_d;
`endif
        end
    end

    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign framing_err = framing_err_q;
    assign send        = send_q;
    assign debug_clear = debug_clear_q;
    assign cmd_error   = cmd_error_q;
`ifdef MSX2P_DEBUG_RX_BREAKPOINT_EN
    assign bp_addr     = bp_addr_q;
    assign bp_valid    = bp_valid_q;
`else
    assign bp_addr     = 16'h0000;
    assign bp_valid    = 1'b0;
`endif

endmodule

// File: tb/tb_msx2p_debug_rx.sv
// Bench for msx2p_debug_rx: serial frame driver, command model feeding an expected-event queue, strobe monitor.
`timescale 1ns/1ps
module tb_msx2p_debug_rx;

    localparam int BIT_CYC = 234;
    localparam int W       = 13;

    logic        clk_27m = 1'b0;
    logic        reset   = 1'b1;
    logic        uart_rx = 1'b1;
    logic [7:0]  rx_data;
    logic        rx_valid, framing_err, send, debug_clear, bp_valid, cmd_error;
    logic [15:0] bp_addr;

    msx2p_debug_rx dut (
        .clk_27m     (clk_27m),
        .reset       (reset),
        .uart_rx     (uart_rx),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .framing_err (framing_err),
        .send        (send),
        .debug_clear (debug_clear),
        .bp_addr     (bp_addr),
        .bp_valid    (bp_valid),
        .cmd_error   (cmd_error)
    );

    // Clock / reset block
    always #5 clk_27m = ~clk_27m;

    int cyc = 0;
    always @(posedge clk_27m) cyc <= cyc + 1;

    // Scoreboard state
    logic [W-1:0] exp_q[$];
    int n_cmp = 0;
    int n_err = 0;
    int frame_start = 0;
    int last_rx_cyc = 0;

    // Command model
    logic [7:0]  m_rx_data;
    logic        m_hex;
    int          m_digits;
    logic [15:0] m_shift;
    logic [15:0] m_bp_addr;
    logic        m_bp_valid;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [7:0] lower_c(input logic [7:0] c);
        return (c >= 8'h41 && c <= 8'h5A) ? (c + 8'h20) : c;
    endfunction

    function automatic int hex_val(input logic [7:0] c);
        if (c >= 8'h30 && c <= 8'h39) return int'(c) - 48;
        if (c >= 8'h61 && c <= 8'h66) return int'(c) - 87;
        return -1;
    endfunction

    task automatic model_reset();
        m_rx_data  = 8'h00;
        m_hex      = 1'b0;
        m_digits   = 0;
        m_shift    = 16'h0;
        m_bp_addr  = 16'h0;
        m_bp_valid = 1'b0;
    endtask

    // Event word: {rx_valid, framing_err, send, debug_clear, cmd_error, rx_data}
    task automatic push_byte(input logic [7:0] b, input logic good);
        logic [7:0] c;
        int hv;
        c  = lower_c(b);
        hv = hex_val(c);
        if (!good) begin
            exp_q.push_back({5'b01000, m_rx_data});
            if (m_hex) begin
                exp_q.push_back({5'b00001, m_rx_data});
                m_hex = 1'b0;
            end
        end else begin
            m_rx_data = b;
            exp_q.push_back({5'b10000, b});
            if (m_hex) begin
                if (hv >= 0) begin
                    m_shift = {m_shift[11:0], 4'(hv)};
                    m_digits++;
                    if (m_digits == 4) begin
                        m_bp_addr  = m_shift;
                        m_bp_valid = 1'b1;
                        m_hex      = 1'b0;
                    end
                end else begin
                    exp_q.push_back({5'b00001, b});
                    m_hex = 1'b0;
                end
            end else if (c == 8'h73) begin
                exp_q.push_back({5'b00100, b});
            end else if (c == 8'h72) begin
                exp_q.push_back({5'b00010, b});
`ifdef MSX2P_DEBUG_RX_BREAKPOINT_EN
            end else if (c == 8'h63) begin
                m_bp_valid = 1'b0;
            end else if (c == 8'h62) begin
                m_hex    = 1'b1;
                m_digits = 0;
                m_shift  = 16'h0;
`endif
            end else if (c == 8'h0d || c == 8'h0a || c == 8'h20) begin
            end else begin
                exp_q.push_back({5'b00001, b});
            end
        end
    endtask

    // Driver tasks: always entered and left on a falling clock edge.
    task automatic drive_bit(input logic v, input int n);
        uart_rx = v;
        repeat (n) @(negedge clk_27m);
    endtask

    task automatic send_frame(input logic [7:0] b, input int stop_low);
        push_byte(b, stop_low == 0);
        frame_start = cyc;
        drive_bit(1'b0, BIT_CYC);
        for (int i = 0; i < 8; i++) drive_bit(b[i], BIT_CYC);
        if (stop_low == 0) begin
            drive_bit(1'b1, BIT_CYC);
        end else begin
            drive_bit(1'b0, stop_low);
            drive_bit(1'b1, 2 * BIT_CYC);
        end
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_frame(s[i], 0);
    endtask

    task automatic check_reset_outs(input string tag);
        check_eq(tag, 32'({rx_data, rx_valid, framing_err, send, debug_clear, cmd_error, bp_addr, bp_valid}), 32'h0);
    endtask

    // Monitor: every strobe cycle is one event popped from the expected queue.
    logic [W-1:0] obs_w;
    logic [W-1:0] exp_w;
    always @(negedge clk_27m) begin
        if (!reset) begin
            obs_w = {rx_valid, framing_err, send, debug_clear, cmd_error, rx_data};
            if (obs_w[12:8] != 5'b0) begin
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_event", 32'(obs_w), 32'h0);
                end else begin
                    exp_w = exp_q.pop_front();
                    check_eq("event", 32'(obs_w), 32'(exp_w));
                end
                if (rx_valid || framing_err) begin
                    last_rx_cyc = cyc;
                    check_eq("frame_latency_ok",
                             32'((cyc - frame_start >= 2215) && (cyc - frame_start <= 2235)), 32'd1);
                end else begin
                    check_eq("cmd_strobe_latency", 32'(cyc - last_rx_cyc), 32'd1);
                end
            end
        end
    end

    initial begin
        model_reset();
        reset   = 1'b1;
        uart_rx = 1'b1;
        repeat (5) @(negedge clk_27m);
        check_reset_outs("reset_outs_initial");
        reset = 1'b0;
        drive_bit(1'b1, BIT_CYC);

        send_frame(8'h73, 0);
        check_eq("rx_data_s", 32'(rx_data), 32'h73);

        send_str("b7B61");
`ifdef MSX2P_DEBUG_RX_BREAKPOINT_EN
        check_eq("bp_addr_7b61", 32'(bp_addr), 32'h7B61);
`endif
        check_eq("bp_addr_after_b", 32'(bp_addr), 32'(m_bp_addr));
        check_eq("bp_valid_after_b", 32'(bp_valid), 32'(m_bp_valid));
        send_str("C");
        check_eq("bp_addr_after_c", 32'(bp_addr), 32'(m_bp_addr));
        check_eq("bp_valid_after_c", 32'(bp_valid), 32'b0);

        send_str("b7B61b1x");
        check_eq("bp_addr_after_bad_hex", 32'(bp_addr), 32'(m_bp_addr));
        check_eq("bp_valid_after_bad_hex", 32'(bp_valid), 32'(m_bp_valid));
        send_str("r");

        send_str("\r\n Sq");
        check_eq("rx_data_q", 32'(rx_data), 32'h71);

        send_str("b12");
        send_frame(8'h41, 160);
        check_eq("ferr_rx_data_hold", 32'(rx_data), 32'h32);
        check_eq("bp_valid_after_ferr", 32'(bp_valid), 32'(m_bp_valid));

        drive_bit(1'b0, 50);
        drive_bit(1'b1, 2 * BIT_CYC);
        send_frame(8'h72, 0);
        check_eq("rx_data_after_glitch", 32'(rx_data), 32'h72);

        // Reset lands in the middle of the data bits.
        frame_start = cyc;
        drive_bit(1'b0, 4 * BIT_CYC);
        reset   = 1'b1;
        uart_rx = 1'b1;
        repeat (3) @(negedge clk_27m);
        check_reset_outs("reset_outs_mid_frame");
        reset = 1'b0;
        model_reset();
        drive_bit(1'b1, BIT_CYC);
        send_frame(8'h52, 0);
        check_eq("rx_data_after_reset", 32'(rx_data), 32'h52);

        repeat (3) send_frame(8'($urandom_range(0, 255)), 0);
        check_eq("bp_valid_final", 32'(bp_valid), 32'(m_bp_valid));

        drive_bit(1'b1, BIT_CYC);
        check_eq("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
